ring_code_checker: RTL and testbench
====================================

# ring_code_checker

Receive-side companion to the team's ring counter. Samples a WIDTH-bit one-hot ring code every enabled cycle, decodes it to a binary index, and checks that consecutive samples advance by exactly one rotate-left step. It acquires lock after a configurable run of good transitions, then flags every sequence violation. It sits downstream of any ring-counter output, as a decoder and self-check monitor.

## Interface
Parameters:
- WIDTH, 4: ring width in bits; must be ≥ 2.
- LOCK_CNT, 3: consecutive good transitions required to assert lock; must be ≥ 1.
- CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; q_in is ignored when low.
- q_in  in  WIDTH  ring code under test.
- idx  out  $clog2(WIDTH)  binary position of the set bit in the last valid one-hot sample.
- onehot_ok  out  1  last enabled sample had exactly one bit set.
- locked  out  1  checker is in LOCKED.
- err  out  1  one-cycle pulse on a sequence violation while LOCKED.
- err_cnt  out  CNT_W  saturating count of err pulses (only with RING_ERR_CNT_EN).

## Operation
- Internal state:
  - FSM state: HUNT, TRACK or LOCKED.
  - prev: the last valid one-hot sample, WIDTH bits.
  - good_cnt: counts 0..LOCK_CNT.
- Expected next code is rotl(prev, 1). The wrap 1000→0001 (WIDTH=4) is legal.
- A sample is one-hot when popcount == 1. 0000 and multi-bit codes are illegal.
- On each edge with en=1:
  - HUNT:
    - One-hot sample → TRACK, prev=q_in, good_cnt=0.
    - Otherwise → stay in HUNT.
  - TRACK:
    - Sample equals rotl(prev) → good_cnt+1, prev=q_in. If good_cnt+1 == LOCK_CNT → LOCKED.
    - One-hot mismatch → stay in TRACK, prev=q_in, good_cnt=0.
    - Non-one-hot sample → HUNT.
  - LOCKED:
    - Sample equals rotl(prev) → stay in LOCKED, prev=q_in.
    - Any mismatch → err=1 for that cycle and err_cnt increments. Next state is TRACK (prev=q_in, good_cnt=0) if the sample is one-hot, else HUNT.
- On each edge with en=0:
  - FSM, prev, good_cnt, idx and onehot_ok hold.
  - err is 0.
- idx updates only on a one-hot sample; otherwise it holds its previous value.
- onehot_ok updates on every enabled sample.
- err_cnt saturates at 2^CNT_W−1 and never wraps.
- No sticky error state; recovery is automatic through TRACK.

## Timing
- All outputs are registered. Latency is 1 cycle: the response to the q_in sampled at edge N is visible after edge N.
- With a clean ring from reset, locked rises after the edge that samples the (LOCK_CNT+1)-th code.
- err is high for exactly one cycle per violation, even on back-to-back violations. It stays 0 in HUNT and TRACK.
- locked falls on the same edge that raises err.
- Reset, applied asynchronously at any time including mid-LOCKED:
  - Outputs clear immediately: idx=0, onehot_ok=0, locked=0, err=0, err_cnt=0.
  - Internal state clears: FSM=HUNT, prev=0, good_cnt=0.
- The first edge after rst deasserts is a normal sample.

## Configuration
- RING_ERR_CNT_EN defined:
  - The err_cnt register and saturating increment are built.
- RING_ERR_CNT_EN undefined:
  - err_cnt is tied to 0 and the counter logic is not synthesized.
  - All other behaviour is identical, including err.

## Test plan
WIDTH=4, LOCK_CNT=3 unless noted.
1. Acquisition:
   - Stimulus: reset, then en=1 with 0001, 0010, 0100, 1000, 0001.
   - Required: idx = 0, 1, 2, 3, 0, each one cycle after its sample. locked=1 after the 1000 sample. err stays 0 throughout, including across the wrap.
2. Violation while locked:
   - Stimulus: lock, then after 1000 feed 0100 instead of 0001.
   - Required: err=1 for one cycle, err_cnt=1, locked=0, FSM=TRACK. Then 1000, 0001, 0010 → locked=1 again.
3. Illegal codes:
   - Stimulus: feed 0000, then 0011.
   - Required: onehot_ok=0 and idx holds its last value. FSM=HUNT if unlocked. If locked: err pulse and exit to HUNT.
4. Enable gating:
   - Stimulus: while locked, en=0 for 5 cycles with q_in=1111, then en=1 with the correct next code.
   - Required: locked stays 1 and err stays 0 throughout.
5. Asynchronous reset:
   - Stimulus: assert rst mid-cycle while locked with err_cnt=2.
   - Required: all outputs are 0 before the next clock edge.
6. Saturation:
   - Stimulus: CNT_W=2, RING_ERR_CNT_EN defined, force 5 violations.
   - Required: err_cnt = 1, 2, 3, 3, 3. With the macro undefined, err_cnt stays 0.

Source files
------------

// File: rtl/ring_code_checker.sv
// One-hot ring code decoder and rotate-left sequence checker with lock/err tracking.
// Optional saturating error counter is built only when RING_ERR_CNT_EN is defined.
module ring_code_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int CNT_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [WIDTH-1:0]         q_in,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     onehot_ok,
   output logic                     locked,
   output logic                     err,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int IDX_W  = $clog2(WIDTH);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic is_onehot(input logic [WIDTH-1:0] v);
      logic [31:0] cnt;
      cnt = 32'd0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + 32'(v[i]);
      end
      return (cnt == 32'd1);
   endfunction

   function automatic logic [IDX_W-1:0] onehot_index(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r = v[i] ? IDX_W'(i) : r;
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [WIDTH-1:0]    prev_r;
   logic [WIDTH-1:0]    prev_nxt_s;
   logic [GOOD_W-1:0]   good_cnt_r;
   logic [GOOD_W-1:0]   good_nxt_s;
   logic [GOOD_W-1:0]   good_inc_s;
   logic [IDX_W-1:0]    idx_r;
   logic                onehot_ok_r;
   logic                locked_r;
   logic                err_r;
   logic                err_nxt_s;
   logic                onehot_s;
   logic                match_s;

   assign onehot_s   = is_onehot(q_in);
   // prev_r is always one-hot outside HUNT, so a match also implies a legal code
   assign match_s    = (q_in == rotl1(prev_r));
   assign good_inc_s = good_cnt_r + GOOD_W'(1);

   // Next-state, tracked sample, good-run counter and violation decode
   always_comb begin
      state_nxt_s = state_r;
      prev_nxt_s  = prev_r;
      good_nxt_s  = good_cnt_r;
      err_nxt_s   = 1'b0;
      if (en) begin
         case (state_r)
            HUNT: begin
               if (onehot_s) begin
                  state_nxt_s = TRACK;
                  prev_nxt_s  = q_in;
                  good_nxt_s  = '0;
               end else begin
                  state_nxt_s = HUNT;
               end
            end
            TRACK: begin
               if (match_s) begin
                  prev_nxt_s = q_in;
                  good_nxt_s = good_inc_s;
                  if (good_inc_s == GOOD_W'(LOCK_CNT)) begin
                     state_nxt_s = LOCKED;
                  end else begin
                     state_nxt_s = TRACK;
                  end
               end else if (onehot_s) begin
                  state_nxt_s = TRACK;
                  prev_nxt_s  = q_in;
                  good_nxt_s  = '0;
               end else begin
                  state_nxt_s = HUNT;
               end
            end
            LOCKED: begin
               if (match_s) begin
                  state_nxt_s = LOCKED;
                  prev_nxt_s  = q_in;
               end else begin
                  err_nxt_s = 1'b1;
                  if (onehot_s) begin
                     state_nxt_s = TRACK;
                     prev_nxt_s  = q_in;
                     good_nxt_s  = '0;
                  end else begin
                     state_nxt_s = HUNT;
                  end
               end
            end
            default: begin
               state_nxt_s = HUNT;
               prev_nxt_s  = '0;
               good_nxt_s  = '0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and registered outputs; idx and onehot_ok hold while disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= HUNT;
         prev_r      <= '0;
         good_cnt_r  <= '0;
         idx_r       <= '0;
         onehot_ok_r <= 1'b0;
         locked_r    <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         prev_r     <= prev_nxt_s;
         good_cnt_r <= good_nxt_s;
         locked_r   <= (state_nxt_s == LOCKED);
         err_r      <= err_nxt_s;
         if (en) begin
            onehot_ok_r <= onehot_s;
         end
         if (en && onehot_s) begin
            idx_r <= onehot_index(q_in);
         end
      end
   end

`ifdef RING_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_r;

   // Saturating count of violations, updated on the same edge that raises err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= '0;
      end else if (err_nxt_s && (err_cnt_r != {CNT_W{1'b1}})) begin
         err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = '0;
`endif

   assign idx       = idx_r;
   assign onehot_ok = onehot_ok_r;
   assign locked    = locked_r;
   assign err       = err_r;

endmodule

// File: tb/tb_ring_code_checker.sv
// Scoreboard bench for ring_code_checker: directed scenarios followed by random ring traffic.
module tb_ring_code_checker;

   localparam int WIDTH    = 4;
   localparam int LOCK_CNT = 3;
   localparam int CNT_W    = 2;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic [WIDTH-1:0] q_in = '0;
   logic [1:0]       idx;
   logic             onehot_ok;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_cnt;

   ring_code_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .q_in(q_in),
      .idx(idx), .onehot_ok(onehot_ok), .locked(locked), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] idx;
      logic       ok;
      logic       lk;
      logic       er;
      logic [1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: position history and run length of good +1 steps
   bit m_have;
   int m_pidx, m_run, m_idx, m_cnt;
   bit m_ok;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int pos_of(input logic [WIDTH-1:0] q);
      for (int i = 0; i < WIDTH; i++) if (q[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_have = 0; m_pidx = 0; m_run = 0; m_idx = 0; m_ok = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit e, input logic [WIDTH-1:0] q, output exp_t x);
      bit oh, was_lk, er;
      int qi;
      er = 0;
      if (e) begin
         oh     = ($countones(q) == 1);
         qi     = pos_of(q);
         was_lk = m_have && (m_run >= LOCK_CNT);
         m_ok   = oh;
         if (!oh) begin
            er = was_lk; m_have = 0; m_run = 0;
         end else begin
            m_idx = qi;
            if (m_have && qi == (m_pidx + 1) % WIDTH) m_run++;
            else begin
               er = was_lk; m_have = 1; m_run = 0;
            end
            m_pidx = qi;
         end
`ifdef RING_ERR_CNT_EN
         if (er && m_cnt < CNT_MAX) m_cnt++;
`endif
      end
      x.idx = 2'(m_idx);
      x.ok  = m_ok;
      x.lk  = m_have && (m_run >= LOCK_CNT);
      x.er  = er;
      x.cnt = 2'(m_cnt);
   endtask

   task automatic step(input bit e, input logic [WIDTH-1:0] q);
      exp_t x;
      @(negedge clk);
      rst  = 1'b0;
      en   = e;
      q_in = q;
      model_step(e, q, x);
      sb.push_back(x);
   endtask

   task automatic nxt();
      step(1'b1, 4'b0001 << ((m_pidx + 1) % WIDTH));
   endtask

   task automatic async_reset();
      @(negedge clk);
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_idx", int'(idx), 0);
      chk("async_onehot_ok", int'(onehot_ok), 0);
      chk("async_locked", int'(locked), 0);
      chk("async_err", int'(err), 0);
      chk("async_err_cnt", int'(err_cnt), 0);
      model_reset();
      sb.push_back(exp_t'(0));
   endtask

   // monitor: compare every registered output one step after each edge
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("idx", int'(idx), int'(x.idx));
         chk("onehot_ok", int'(onehot_ok), int'(x.ok));
         chk("locked", int'(locked), int'(x.lk));
         chk("err", int'(err), int'(x.er));
         chk("err_cnt", int'(err_cnt), int'(x.cnt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_idx", int'(idx), 0);
      chk("reset_onehot_ok", int'(onehot_ok), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_err_cnt", int'(err_cnt), 0);

      // acquisition across the wrap
      step(1'b1, 4'b0001); step(1'b1, 4'b0010); step(1'b1, 4'b0100);
      step(1'b1, 4'b1000); step(1'b1, 4'b0001);
      // violation while locked, then relock
      step(1'b1, 4'b0010); step(1'b1, 4'b0100); step(1'b1, 4'b1000);
      step(1'b1, 4'b0100);
      step(1'b1, 4'b1000); step(1'b1, 4'b0001); step(1'b1, 4'b0010);
      // illegal codes: zero while locked, then multi-bit while hunting
      step(1'b1, 4'b0000); step(1'b1, 4'b0011);
      step(1'b1, 4'b0001); step(1'b1, 4'b0010); step(1'b1, 4'b0100); step(1'b1, 4'b1000);
      // enable gating with garbage on the bus
      repeat (5) step(1'b0, 4'b1111);
      nxt();
      async_reset();
      // saturation: five forced violations, each from a fresh lock
      repeat (5) begin
         step(1'b1, 4'b0001); step(1'b1, 4'b0010); step(1'b1, 4'b0100); step(1'b1, 4'b1000);
         step(1'b1, 4'b0100);
      end
      // random traffic biased toward a clean ring
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            6:       step(1'b1, 4'b0001 << $urandom_range(0, 3));
            7:       step(1'b1, 4'b0000);
            8:       step(1'b1, 4'($urandom));
            9:       step(1'b0, 4'($urandom));
            default: nxt();
         endcase
         if (i % 137 == 136) async_reset();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
